// File: rtl/uart_rx.sv
// 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to build the 8E1 variant with a parity_err output.
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLK_IN,
   input  logic       RST,
   input  logic       RX,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rx_empty,
   output logic       rx_full,
   output logic       overrun,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   // state  | meaning
   // IDLE   | waiting for a 1->0 edge on rx_s
   // START  | half-bit wait, then confirm start bit is still low
   // DATA   | sample 8 data bits LSB-first, one per bit period
   // PARITY | sample even-parity bit (parity build only)
   // STOP   | sample stop bit, push byte or raise an error flag

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic          rx_meta, rx_s, rx_d;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   logic          set_pe;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic tick, do_pop, do_push, set_ovr, set_fe;

   assign tick     = (cnt == '0);
   assign rd_data  = mem[rd_ptr];
   assign rx_empty = (count == '0);
   assign rx_full  = (count == DEPTH_C);

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   always_comb begin
      do_pop  = rd_en && (count != '0);
      do_push = 1'b0;
      set_ovr = 1'b0;
      set_fe  = 1'b0;
`ifdef UART_RX_PARITY_EN
      set_pe  = 1'b0;
`endif
      if (state == STOP && tick) begin
         if (!rx_s)
            set_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
         else if (^{shreg, par_bit})
            set_pe = 1'b1;
`endif
         else if (count == DEPTH_C && !do_pop)
            set_ovr = 1'b1;
         else
            do_push = 1'b1;
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         state     <= IDLE;
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_d      <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;

         case (state)
            IDLE: begin
               if (rx_d && !rx_s) begin
                  cnt   <= HALF_RELOAD;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  cnt <= FULL_RELOAD;
                  if (!rx_s) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  cnt     <= FULL_RELOAD;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PARITY: begin
               if (tick) begin
                  cnt   <= FULL_RELOAD;
`ifdef UART_RX_PARITY_EN
                  par_bit <= rx_s;
`endif
                  state <= STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  cnt   <= FULL_RELOAD;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // A set event in the same cycle as clr_err keeps the flag set.
         if (set_ovr)      overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
         if (set_fe)       frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (set_pe)       parity_err <= 1'b1;
         else if (clr_err) parity_err <= 1'b0;
`endif
      end
   end

endmodule
